up_counter: RTL and testbench
=============================

# up_counter

Two-bit up counter built as a four-state Moore machine. It advances one state per clock while its enable input is high. It raises a single-bit terminal-count flag while it sits in the last state. It is a leaf block used as a small event/phase counter; the flag feeds downstream control logic.

## Interface
- Parameters: none; the state width is fixed at 2 bits.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
- in  input  1  count enable; high = advance one state on this edge, low = hold.
- out  output  1  terminal-count flag; high exactly while the state is S3.

## Operation
- States and encodings: S0=2'b00, S1=2'b01, S2=2'b10, S3=2'b11. The state is held in a 2-bit register.
- Transitions, evaluated at each rising edge of clk:
  - reset==0: next state = S0, whatever the value of in. Reset has priority over everything else.
  - reset==1, in==1: S0->S1, S1->S2, S2->S3, S3->S0. The wrap from S3 to S0 is silent: no sticky overflow.
  - reset==1, in==0: the state holds.
- Output (Moore): out = (state == S3). It depends on the state only, never directly on in.
- Reset values: state = S0, out = 0.
- Power-up before the first reset is unspecified. The bench must apply reset before checking anything.
- X on in while reset==1 is a bench error and is not handled.

## Timing
- The state updates only on rising edges of clk.
- out is decoded combinationally from the state register, so it changes in the same cycle as the state. It never changes between edges.
- Latency from in to out: out goes high on the clock edge that loads S3. That is the third enabled edge counted from S0.
- With in held high continuously, out is high for 1 cycle in every 4 (period 4).
- Reset asserted mid-count, including while in S3: at the next edge the state becomes S0 and out drops to 0.
- Reset released with in==1 on the same edge: that edge still loads S0. Counting starts on the following edge.
- Enable gaps: counting resumes from the held state, and no count is lost or duplicated.

## Structure
- Shared package holds:
  - the 2-bit state typedef/enum (S0..S3);
  - the constant TERM_STATE = S3.
- Keep three separate pieces:
  - the state register (one always_ff with the synchronous active-low reset);
  - the next-state logic (combinational case on state and in);
  - the output decode.
- No sub-modules.

## Test plan
- Reset: hold reset=0 for 2 edges with in=1. Required: state=S0 and out=0 after each edge.
- Free run: reset=1, in=1 for 8 edges from S0. Required: states 1,2,3,0,1,2,3,0; out = 0,0,1,0,0,0,1,0.
- Hold: from S2, drive in=0 for 3 edges. Required: state stays S2 and out=0. Then in=1 for 1 edge: state S3, out=1.
- Hold in S3: reach S3, then in=0 for 2 edges. Required: out stays 1 and the state stays S3.
- Reset mid-operation: in S3 with in=1, assert reset=0 for 1 edge. Required: state S0, out=0 (reset beats the wrap). Release reset with in=1: the next edge gives S1.
- Random enable: drive 200 edges of random in with reset=1. Required: out==1 exactly when (number of enabled edges since reset) mod 4 == 3.

Source files
------------

// File: rtl/up_counter_pkg.sv
// Shared types and constants for the two-bit up counter.
package up_counter_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_e;

  localparam state_e TERM_STATE = S3;

endpackage

// File: rtl/up_counter.sv
// Two-bit Moore up counter; out flags the terminal state S3.
module up_counter
  import up_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);

  state_e r_state;
  state_e w_state_nxt;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S0;
    else        r_state <= w_state_nxt;
  end

  // S3 wraps silently to S0; no overflow is recorded.
  always_comb begin
    w_state_nxt = r_state;
    if (in) begin
      case (r_state)
        S0:      w_state_nxt = S1;
        S1:      w_state_nxt = S2;
        S2:      w_state_nxt = S3;
        S3:      w_state_nxt = S0;
        default: w_state_nxt = S0;
      endcase
    end
  end

  assign out = (r_state == TERM_STATE);

endmodule

// File: tb/tb_up_counter.sv
// Directed and random-enable checks for up_counter.
module tb_up_counter;

  logic clk;
  logic reset;
  logic in;
  logic out;

  int n_chk;
  int n_pass;
  int cnt;

  up_counter dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Apply inputs, take one edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic en);
    reset = rst;
    in    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag, input int st, input int o);
    chk({tag, "_state"}, 32'(dut.r_state), st);
    chk({tag, "_out"},   32'(out),         o);
  endtask

  initial begin
    int fr_st [8];
    int fr_out[8];
    fr_st  = '{1, 2, 3, 0, 1, 2, 3, 0};
    fr_out = '{0, 0, 1, 0, 0, 0, 1, 0};
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    in     = 1'b1;
    #2;

    // Reset held two edges with enable high
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1);
      chk_st("reset", 0, 0);
    end

    // Free run
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      chk_st($sformatf("run%0d", i), fr_st[i], fr_out[i]);
    end

    // Advance to S2, then hold
    step(1'b1, 1'b1); chk_st("to_s1", 1, 0);
    step(1'b1, 1'b1); chk_st("to_s2", 2, 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk_st($sformatf("hold_s2_%0d", i), 2, 0);
    end
    step(1'b1, 1'b1); chk_st("s2_to_s3", 3, 1);

    // Hold in S3
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      chk_st($sformatf("hold_s3_%0d", i), 3, 1);
    end

    // Reset beats the wrap from S3
    step(1'b0, 1'b1); chk_st("rst_in_s3", 0, 0);
    step(1'b1, 1'b1); chk_st("post_rst", 1, 0);

    // Reset released with enable high still loads S0 on that edge
    step(1'b0, 1'b1); chk_st("rst_again", 0, 0);

    // Random enable against a running count
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      logic en;
      en = 1'($urandom_range(0, 1));
      step(1'b1, en);
      if (en) cnt++;
      chk_st($sformatf("rnd%0d", i), cnt % 4, ((cnt % 4) == 3) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
